// File: rtl/prng_lfsr_pkg.sv
// ---------------------------------------------------------------------------
// prng_lfsr_pkg : LFSR mode encoding, mode masks and XNOR feedback taps.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package prng_lfsr_pkg;

  localparam int STATE_MAX = 128;
  localparam int MODE_W    = 8;

  typedef enum logic [MODE_W-1:0] {
    MODE_8   = 8'd8,
    MODE_16  = 8'd16,
    MODE_20  = 8'd20,
    MODE_32  = 8'd32,
    MODE_40  = 8'd40,
    MODE_52  = 8'd52,
    MODE_64  = 8'd64,
    MODE_80  = 8'd80,
    MODE_96  = 8'd96,
    MODE_128 = 8'd128
  } mode_t;

  localparam mode_t MODE_DEFAULT = MODE_32;

  // Unsupported lengths fall back to the default mode.
  function automatic mode_t decode_mode(input logic [MODE_W-1:0] m);
    mode_t r;
    case (m)
      8'd8:    r = MODE_8;
      8'd16:   r = MODE_16;
      8'd20:   r = MODE_20;
      8'd32:   r = MODE_32;
      8'd40:   r = MODE_40;
      8'd52:   r = MODE_52;
      8'd64:   r = MODE_64;
      8'd80:   r = MODE_80;
      8'd96:   r = MODE_96;
      8'd128:  r = MODE_128;
      default: r = MODE_DEFAULT;
    endcase
    return r;
  endfunction

  function automatic logic [STATE_MAX-1:0] mode_mask(input mode_t mode);
    logic [STATE_MAX-1:0] r;
    if (mode == MODE_128) r = '1;
    else                  r = (128'd1 << mode) - 128'd1;
    return r;
  endfunction

  function automatic logic next_bit(input logic [STATE_MAX-1:0] s, input mode_t mode);
    logic x;
    case (mode)
      MODE_8:   x = s[7]   ^ s[5]   ^ s[4]   ^ s[3];
      MODE_16:  x = s[15]  ^ s[14]  ^ s[12]  ^ s[3];
      MODE_20:  x = s[19]  ^ s[16];
      MODE_40:  x = s[39]  ^ s[37]  ^ s[20]  ^ s[18];
      MODE_52:  x = s[51]  ^ s[48];
      MODE_64:  x = s[63]  ^ s[62]  ^ s[60]  ^ s[59];
      MODE_80:  x = s[79]  ^ s[78]  ^ s[42]  ^ s[41];
      MODE_96:  x = s[95]  ^ s[93]  ^ s[48]  ^ s[46];
      MODE_128: x = s[127] ^ s[125] ^ s[100] ^ s[98];
      default:  x = s[31]  ^ s[21]  ^ s[1]   ^ s[0];
    endcase
    return ~x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prng_lfsr_stream_if.sv
// ---------------------------------------------------------------------------
// prng_lfsr_stream_if : seed/mode load and word stream bundle.
// master = controlling/consuming side, slave = generator.
// Optional lockup flag under PRNG_LFSR_LOCKUP_DET_EN. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface prng_lfsr_stream_if #(
  parameter int MAX_W = 128,
  parameter int OUT_W = 8
);
  localparam int LM_W = $clog2(MAX_W) + 1;

  logic             load;
  logic [LM_W-1:0]  load_mode;
  logic [MAX_W-1:0] load_seed;
  logic             enable;
  logic             out_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
`ifdef PRNG_LFSR_LOCKUP_DET_EN
  logic             lockup;
`endif

  modport master (
    output load, load_mode, load_seed, enable, out_ready,
    input  out_valid, out_data
`ifdef PRNG_LFSR_LOCKUP_DET_EN
    , input lockup
`endif
  );

  modport slave (
    input  load, load_mode, load_seed, enable, out_ready,
    output out_valid, out_data
`ifdef PRNG_LFSR_LOCKUP_DET_EN
    , output lockup
`endif
  );

endinterface

`default_nettype wire

// File: rtl/prng_lfsr_step.sv
// ---------------------------------------------------------------------------
// prng_lfsr_step : one combinational XNOR Fibonacci shift, masked to the mode.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prng_lfsr_step
  import prng_lfsr_pkg::*;
#(
  parameter int MAX_W = 128
) (
  input  wire logic [MAX_W-1:0] state_i,
  input  wire mode_t            mode_i,
  output logic      [MAX_W-1:0] state_o
);

  logic [STATE_MAX-1:0] w_ext;
  logic [STATE_MAX-1:0] w_next;

  always_comb begin
    w_ext              = '0;
    w_ext[MAX_W-1:0]   = state_i;
    w_next             = {w_ext[STATE_MAX-2:0], next_bit(w_ext, mode_i)} & mode_mask(mode_i);
    state_o            = w_next[MAX_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/prng_lfsr_stream.sv
// ---------------------------------------------------------------------------
// prng_lfsr_stream : OUT_W-step XNOR LFSR word generator on a valid/ready
// stream. PRNG_LFSR_LOCKUP_DET_EN adds lockup detection and recovery.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prng_lfsr_stream
  import prng_lfsr_pkg::*;
#(
  parameter int MAX_W = 128,
  parameter int OUT_W = 8
) (
  input  wire logic         clock,
  input  wire logic         resetn,
  prng_lfsr_stream_if.slave bus
);

  localparam int LM_W = $clog2(MAX_W) + 1;

  logic [MAX_W-1:0]     state_q, state_d;
  mode_t                mode_q, mode_d;
  logic                 valid_q, valid_d;
  logic [OUT_W-1:0]     data_q, data_d;

  logic [MODE_W-1:0]    w_lm_ext;
  mode_t                w_load_mode;
  logic [STATE_MAX-1:0] w_load_mask;
  logic [MAX_W-1:0]     w_seed_masked;
  logic [MAX_W-1:0]     w_base;
  logic [MAX_W-1:0]     w_chain [OUT_W+1];
  logic                 w_fire;

`ifdef PRNG_LFSR_LOCKUP_DET_EN
  logic                 lockup_q, lockup_d;
  logic [STATE_MAX-1:0] w_mode_mask;
  logic                 w_run_lock;
`endif

  always_comb begin
    w_lm_ext               = '0;
    w_lm_ext[LM_W-1:0]     = bus.load_mode;
    w_load_mode            = decode_mode(w_lm_ext);
    w_load_mask            = mode_mask(w_load_mode);
    w_seed_masked          = bus.load_seed & w_load_mask[MAX_W-1:0];
  end

  // The all-ones XNOR lockup state is replaced by zero before stepping.
`ifdef PRNG_LFSR_LOCKUP_DET_EN
  always_comb begin
    w_mode_mask = mode_mask(mode_q);
    w_run_lock  = (state_q == w_mode_mask[MAX_W-1:0]);
    w_base      = w_run_lock ? '0 : state_q;
  end
`else
  assign w_base = state_q;
`endif

  assign w_chain[0] = w_base;

  for (genvar i = 0; i < OUT_W; i++) begin : g_step
    prng_lfsr_step #(
      .MAX_W (MAX_W)
    ) u_step (
      .state_i (w_chain[i]),
      .mode_i  (mode_q),
      .state_o (w_chain[i+1])
    );
  end

  assign w_fire = bus.enable & ~bus.load & (~valid_q | bus.out_ready);

  always_comb begin
    state_d  = w_base;
    mode_d   = mode_q;
    valid_d  = valid_q;
    data_d   = data_q;
`ifdef PRNG_LFSR_LOCKUP_DET_EN
    lockup_d = lockup_q;
`endif
    if (bus.load) begin
      state_d  = w_seed_masked;
      mode_d   = w_load_mode;
      valid_d  = 1'b0;
`ifdef PRNG_LFSR_LOCKUP_DET_EN
      lockup_d = 1'b0;
      if (w_seed_masked == w_load_mask[MAX_W-1:0]) begin
        state_d  = '0;
        lockup_d = 1'b1;
      end
`endif
    end else begin
`ifdef PRNG_LFSR_LOCKUP_DET_EN
      if (w_run_lock) lockup_d = 1'b1;
`endif
      if (w_fire) begin
        state_d = w_chain[OUT_W];
        valid_d = 1'b1;
        data_d  = w_chain[OUT_W][OUT_W-1:0];
      end else if (valid_q && bus.out_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= '0;
      mode_q   <= MODE_DEFAULT;
      valid_q  <= 1'b0;
      data_q   <= '0;
`ifdef PRNG_LFSR_LOCKUP_DET_EN
      lockup_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
`ifdef PRNG_LFSR_LOCKUP_DET_EN
      lockup_q <= lockup_d;
`endif
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
`ifdef PRNG_LFSR_LOCKUP_DET_EN
  assign bus.lockup    = lockup_q;
`endif

endmodule

`default_nettype wire

// File: doc/prng_lfsr_stream.md
# prng_lfsr_stream

Parametrised multi-bit successor to the single-bit PRNG LFSR. It advances a mode-selectable XNOR Fibonacci LFSR OUT_W steps per accepted word. Each word is delivered on a valid/ready stream, and the block supports runtime seed loading and optional lockup protection. It sits in the random-data generation path, feeding symbol builders and test-pattern sources that need more than one bit per clock and apply backpressure.

## Interface
- MAX_W, 128: state register width; largest supported mode.
- OUT_W, 8: bits per output word; legal range 1..8, so it never exceeds the smallest mode.
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe; captures load_mode and load_seed.
- load_mode  in  $clog2(MAX_W)+1  requested LFSR length.
- load_seed  in  MAX_W  initial state; bits at or above the mode width are ignored.
- enable  in  1  permits generation of new words.
- out_ready  in  1  consumer accepts out_data.
- out_valid  out  1  out_data holds a word.
- out_data  out  OUT_W  generated word; the first-generated bit is the MSB.
- lockup  out  1  sticky lockup flag; present only with the macro defined.

## Operation
- Modes and taps, XNOR feedback, state shifts left with feedback into bit 0:
  - 8: taps 7,5,4,3
  - 16: taps 15,14,12,3
  - 20: taps 19,16
  - 32: taps 31,21,1,0
  - 40: taps 39,37,20,18
  - 52: taps 51,48
  - 64: taps 63,62,60,59
  - 80: taps 79,78,42,41
  - 96: taps 95,93,48,46
  - 128: taps 127,125,100,98
- Any other load_mode value selects mode 32.
- One word is OUT_W unrolled single steps. The new word is bits [OUT_W-1:0] of the resulting state, i.e. the OUT_W feedback bits with the first one in the MSB.
- A word is generated when out_valid is 0, or when out_valid and out_ready are both 1, provided enable is 1 and load is 0. In either case the state advances by OUT_W steps.
- enable low: no new word is generated. A held valid word stays valid and unchanged until it is consumed.
- load: state <= load_seed masked to the mode width; mode register updated; out_valid <= 0 (pending word discarded); lockup cleared.
- Lockup (macro only): the all-ones state in the mode width is the XNOR lockup state. If a load seed or the running state equals it, the state is forced to 0 and lockup <= 1.

## Timing
- Reset values: state 0, mode 32, out_valid 0, out_data 0, lockup 0. Reset is asynchronous, taking effect regardless of any in-flight handshake.
- Latency: load sampled at edge N, then out_valid = 1 after edge N+1 if enable = 1.
- Throughput: one word per clock while out_ready = 1.
- out_valid never deasserts without a handshake, except on load or reset.
- Simultaneous load and a handshake: load wins; the accepted word is the last one from the old sequence.
- enable deasserted in the same cycle as a handshake: out_valid <= 0 after that edge.

## Configuration
- PRNG_LFSR_LOCKUP_DET_EN defined:
  - lockup port and lockup detection/recovery are present.
  - An all-ones seed restarts from state 0.
- PRNG_LFSR_LOCKUP_DET_EN undefined:
  - no lockup port.
  - An all-ones seed yields a constant all-ones stream.

## Structure
- Package prng_lfsr_pkg:
  - mode_t enum (8 … 128).
  - MODE_DEFAULT = 32.
  - function next_bit(state, mode) returning the XNOR feedback for each mode.
- Sub-module prng_lfsr_step: combinational, one state plus mode in, next state out. Instantiated OUT_W times in a generate chain.
- Top level holds the state, mode and output registers, plus the handshake logic.

## Test plan
- Reset release, enable=1, out_ready=1, no load (mode 32, state 0) -> first word 0x92 one cycle after enable is sampled.
- load mode 8, seed 0x00, then enable -> first word 0xF4; the state afterwards is 0xF4.
- After the first word in the previous scenario, hold out_ready=0 for 5 cycles -> out_valid stays 1 and out_data holds 0xF4; releasing ready produces exactly one advance.
- load mode 8, seed 0xFF with the macro defined -> lockup=1 and first word 0xF4. Without the macro -> every word is 0xFF.
- load_mode=33, seed 0 -> behaves as mode 32, first word 0x92.
- Assert resetn mid-stream while a word is valid and stalled -> out_valid=0 immediately. After release, regenerating from the defaults reproduces 0x92.
